serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor computing A − B LSB-first, one bit per clock, through a registered borrow. It is the subtraction counterpart of the team's adder blocks. It trades latency for a single-bit datapath, and it reuses a `half_subtractor` cell pair in place of the adder's half-adder pair. Operands enter through a valid/ready start handshake, and the result is held on the outputs until the next operation completes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2–32.
- `clk`  in  1: sole clock, rising-edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start_valid`  in  1: requester has operands on `a`/`b`.
- `start_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: minuend, unsigned; sampled on accept.
- `b`  in  WIDTH: subtrahend, unsigned; sampled on accept.
- `busy`  out  1: subtraction in progress.
- `diff`  out  WIDTH: (a − b) mod 2^WIDTH of the last completed operation.
- `bout`  out  1: final borrow of the last completed operation; 1 iff a < b.
- `done`  out  1: one-cycle pulse when `diff`/`bout` update.

## Operation
- **States:** IDLE, SHIFT, DONE.
  - IDLE → SHIFT on accept.
  - SHIFT → DONE when the bit counter reaches WIDTH−1.
  - DONE → IDLE unconditionally.
- **Accept:** `start_valid && start_ready` at a rising edge.
- **On accept:**
  - `a` and `b` load into internal shift registers.
  - Borrow flop clears to 0.
  - Bit counter clears to 0.
- **Per SHIFT cycle, with ai/bi the LSBs of the shift registers and br the borrow flop:**
  - d = ai ^ bi ^ br
  - br' = (~ai & bi) | (~(ai ^ bi) & br)
  - d shifts into the MSB of the result shift register.
  - Both operand registers shift right by one.
- **On the SHIFT → DONE edge:**
  - The completed result shift register copies to `diff`.
  - The final borrow copies to `bout`.
  - `done` asserts for exactly the DONE cycle.
- **Output stability:** `diff`/`bout` change only on the SHIFT → DONE edge. They remain stable while the next operation runs.
- **Handshake:**
  - `start_ready` = (state == IDLE), decoded combinationally from state.
  - `busy` = (state == SHIFT).
  - `start_valid` outside IDLE is ignored. The operands are not captured and no error is raised.
- **Reset (any time, including mid-SHIFT):**
  - state = IDLE, `diff` = 0, `bout` = 0, `done` = 0, `busy` = 0.
  - `start_ready` = 1 immediately after reset.
  - An aborted operation never produces `done`.

## Timing
- The accept edge is E0.
- SHIFT occupies the cycles after edges E0 … E(WIDTH−1).
- `done` is high in the cycle following edge E(WIDTH). This gives WIDTH+1 cycles of latency from accept to the `done` cycle.
- `start_ready` is high again in the cycle after `done`. The minimum accept-to-accept interval is therefore WIDTH+2 cycles.
- No combinational path exists from `a`/`b`/`start_valid` to any output.
- `start_ready` depends on state only.

## Structure
- **Shared package/header `subtractor_pkg`:**
  - State encodings ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2.
  - Counter width macro: clog2(WIDTH).
- **Sub-module `half_subtractor`:**
  - Ports a, b → diff, borrow, with diff = a ^ b and borrow = ~a & b.
  - Instantiated twice to form the per-bit full subtractor; the borrow-OR is done in the parent.
- **Parent (`serial_subtractor`) contains:**
  - FSM
  - bit counter
  - three WIDTH-bit shift registers
  - borrow flop
  - output registers

## Test plan
All scenarios use WIDTH = 8.
- Reset asserted with no stimulus → `diff` = 0x00, `bout` = 0, `done` = 0, `busy` = 0, `start_ready` = 1.
- a = 200, b = 55, accepted at E0 → `done` = 1 in the cycle after E8 only; `diff` = 0x91 (145), `bout` = 0.
- a = 5, b = 9 → `diff` = 0xFC, `bout` = 1. Also a = 0x00, b = 0x01 → `diff` = 0xFF, `bout` = 1.
- Edge operands:
  - a = 0xFF, b = 0xFF → `diff` = 0x00, `bout` = 0.
  - a = 0, b = 0 → `diff` = 0x00, `bout` = 0.
- Ignored start: accept a = 10, b = 3; hold `start_valid` with a = 1, b = 2 throughout SHIFT → only `diff` = 0x07, `bout` = 0 is produced. The second request is accepted only once `start_ready` returns and yields `diff` = 0xFF, `bout` = 1. `diff` stays 0x07 while the second operation is busy.
- Reset mid-op: accept a = 100, b = 1 with previous result 0x07; pull `rst_n` low after 3 SHIFT cycles → `diff` = 0, `bout` = 0, `done` never pulses, and the next accept of a = 3, b = 1 yields `diff` = 0x02, `bout` = 0.

Source files
------------

// File: rtl/subtractor_pkg.sv
// Shared definitions for the serial subtractor: FSM encodings and counter sizing.
package subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit-counter width; must hold WIDTH-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor; two of these plus an OR make a full subtractor.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned A - B, LSB first, one bit per clock through a registered borrow.
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             br_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, done_q;

  logic d0, b0, d_bit, b1, br_d;

  half_subtractor u_hs0 (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .diff   (d0),
    .borrow (b0)
  );

  half_subtractor u_hs1 (
    .a      (d0),
    .b      (br_q),
    .diff   (d_bit),
    .borrow (b1)
  );

  assign br_d = b0 | b1;

  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  assign res_d    = {d_bit, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_valid) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            // Publish the final bit straight from res_d so diff updates on this edge.
            diff_q  <= res_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_SHIFT);
  assign diff        = diff_q;
  assign bout        = bout_q;
  assign done        = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a, b;
  logic         busy;
  logic [W-1:0] diff;
  logic         bout;
  logic         done;

  int passes = 0;
  int total  = 0;

  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .diff        (diff),
    .bout        (bout),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called just after a negedge with the block idle. Presents (av,bv); if hold is set,
  // start_valid stays high after accept with (hav,hbv) on the operand bus.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                    input bit hold, input logic [W-1:0] hav, input logic [W-1:0] hbv);
    logic [W-1:0] exp_d;
    logic         exp_b;
    exp_d = W'(av - bv);
    exp_b = (av < bv);
    start_valid = 1'b1;
    a = av;
    b = bv;
    chk("ready_before_accept", start_ready, 1);
    @(posedge clk);
    #1;
    if (hold) begin
      a = hav;
      b = hbv;
    end else begin
      start_valid = 1'b0;
    end
    for (int i = 0; i <= W; i++) begin
      @(negedge clk);
      chk("done_timing", done, (i == W));
      if (i < W) begin
        chk("busy", busy, 1);
        chk("ready_low", start_ready, 0);
        chk("diff_stable", diff, last_diff);
        chk("bout_stable", bout, last_bout);
      end else begin
        chk("busy_done", busy, 0);
        chk("diff", diff, exp_d);
        chk("bout", bout, exp_b);
      end
    end
    last_diff = exp_d;
    last_bout = exp_b;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", start_ready, 1);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    a           = '0;
    b           = '0;
    repeat (2) @(negedge clk);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", start_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    op(8'd200, 8'd55, 0, 0, 0);
    op(8'd5,   8'd9,  0, 0, 0);
    op(8'h00,  8'h01, 0, 0, 0);
    op(8'hFF,  8'hFF, 0, 0, 0);
    op(8'h00,  8'h00, 0, 0, 0);

    // Held start during SHIFT is ignored, then accepted when ready returns.
    op(8'd10, 8'd3, 1, 8'd1, 8'd2);
    chk("held_result", diff, 8'h07);
    op(8'd1, 8'd2, 0, 0, 0);

    op(8'd10, 8'd3, 0, 0, 0);

    // Abort mid-operation with reset.
    start_valid = 1'b1;
    a = 8'd100;
    b = 8'd1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midop_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", start_ready, 1);
    last_diff = '0;
    last_bout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", done, 0);
    end
    op(8'd3, 8'd1, 0, 0, 0);

    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      op(ra, rb, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
